// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter used as a timeout/delay generator.
// A start value is accepted over a valid/ready handshake. While running, the
// count decrements once every PRESCALE enabled clocks, and a one-cycle done
// pulse is raised when the count expires.
//
// Build option: define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN for periodic mode.
// In that mode the last loaded value is reloaded at every expiry and the block
// stays in RUN. Without the macro the block is one-shot and returns to IDLE.
//
// Ports:
//   clk        - clock; all state updates on posedge
//   reset      - synchronous, active-high reset
//   load_valid - producer offers a start value
//   load_ready - block can accept a value (combinational: IDLE and no abort)
//   load_value - start value, sampled on handshake
//   enable     - count enable; low freezes count and prescaler
//   abort      - cancel a running count (no done pulse)
//   count      - current remaining count (registered)
//   busy       - high while in RUN (registered)
//   done       - one-cycle expiry pulse (registered)
module down_counter_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             handshake;
  logic             tick;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Abort blocks acceptance even in IDLE.
  assign load_ready = (state_q == IDLE) & ~abort;
  assign handshake  = load_valid & load_ready;
  // Prescaler wraps on this enabled clock: time for one decrement.
  assign tick       = enable & (pre_q == PW'(PRESCALE - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
          if (load_value != '0) begin
            count_d = load_value;
            pre_d   = '0;
            state_d = RUN;
          end else begin
            // Zero load expires immediately without entering RUN.
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          // Abort wins over a coincident expiry: no done pulse.
          count_d = '0;
          pre_d   = '0;
          state_d = IDLE;
        end else if (enable) begin
          if (tick) begin
            pre_d = '0;
            if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = IDLE;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers; reset has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: PRESCALE=1 and PRESCALE=4 instances
// share one stimulus stream; each scenario checks the instance it targets.
module tb_down_counter_timer;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             abort;

  logic             ready1, busy1, done1;
  logic [WIDTH-1:0] count1;
  logic             ready4, busy4, done4;
  logic [WIDTH-1:0] count4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready1),
    .load_value(load_value), .enable(enable), .abort(abort),
    .count(count1), .busy(busy1), .done(done1)
  );

  down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready4),
    .load_value(load_value), .enable(enable), .abort(abort),
    .count(count4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    enable     = 1'b0;
    abort      = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Check the PRESCALE=1 instance's full observable state.
  task automatic chk1(input string tag, input int c, input bit b, input bit d);
    check({tag, ".count"}, 32'(count1), 32'(c));
    check({tag, ".busy"},  32'(busy1),  32'(b));
    check({tag, ".done"},  32'(done1),  32'(d));
  endtask

  initial begin
    int cyc;
    bit seen_done;

    // Reset state
    do_reset();
    chk1("rst", 0, 0, 0);
    check("rst.ready", 32'(ready1), 32'd1);
    check("rst.count4", 32'(count4), 32'd0);

    // PRESCALE=1: load 3 -> 3,2,1,0
    enable = 1'b1; load_valid = 1'b1; load_value = 8'd3;
    step();
    load_valid = 1'b0;
    chk1("p1.ld", 3, 1, 0);
    check("p1.ready_run", 32'(ready1), 32'd0);
    step(); chk1("p1.c2", 2, 1, 0);
    step(); chk1("p1.c1", 1, 1, 0);
    step(); chk1("p1.c0", 0, 0, 1);
    check("p1.ready_back", 32'(ready1), 32'd1);
    step(); chk1("p1.after", 0, 0, 0);

    // PRESCALE=4: load 2 -> 2 for 4 cycles, 1 for 4 cycles, then 0 + done
    do_reset();
    enable = 1'b1; load_valid = 1'b1; load_value = 8'd2;
    step();
    load_valid = 1'b0;
    check("p4.ld", 32'(count4), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("p4.cnt%0d", i), 32'(count4), (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : 32'd0);
      check($sformatf("p4.done%0d", i), 32'(done4), (i == 8) ? 32'd1 : 32'd0);
    end
    check("p4.busy_end", 32'(busy4), 32'd0);

    // Enable pause: load 5, freeze 3 cycles at count 3, done after 8 cycles
    do_reset();
    enable = 1'b1; load_valid = 1'b1; load_value = 8'd5;
    step();
    load_valid = 1'b0;
    step(); step();
    check("en.pre", 32'(count1), 32'd3);
    enable = 1'b0;
    step(); step(); step();
    chk1("en.frozen", 3, 1, 0);
    enable = 1'b1;
    cyc = 5;
    seen_done = 1'b0;
    while (!seen_done && cyc < 30) begin
      step();
      cyc++;
      seen_done = done1;
    end
    check("en.cycles", 32'(cyc), 32'd8);
    check("en.count0", 32'(count1), 32'd0);

    // Abort at count 2, with load_valid held high
    do_reset();
    enable = 1'b1; load_valid = 1'b1; load_value = 8'd4;
    step();
    load_valid = 1'b0;
    step(); step();
    check("ab.pre", 32'(count1), 32'd2);
    abort = 1'b1; load_valid = 1'b1; load_value = 8'd7;
    step();
    chk1("ab.next", 0, 0, 0);
    check("ab.ready", 32'(ready1), 32'd0);
    step();
    chk1("ab.nohs", 0, 0, 0);
    abort = 1'b0; load_valid = 1'b0;
    step();
    chk1("ab.idle", 0, 0, 0);

    // Load 0: immediate done, never busy
    do_reset();
    load_valid = 1'b1; load_value = 8'd0;
    step();
    load_valid = 1'b0;
    chk1("z.done", 0, 0, 1);
    step();
    chk1("z.after", 0, 0, 0);

    // Reset mid-run after 2 decrements
    enable = 1'b1; load_valid = 1'b1; load_value = 8'd6;
    step();
    load_valid = 1'b0;
    step(); step();
    check("rr.pre", 32'(count1), 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("rr.post", 0, 0, 0);
    check("rr.ready", 32'(ready1), 32'd1);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // Auto reload: 2,1,2,1 with done on each reload, abort to IDLE
    do_reset();
    enable = 1'b1; load_valid = 1'b1; load_value = 8'd2;
    step();
    load_valid = 1'b0;
    chk1("ar.ld", 2, 1, 0);
    step(); chk1("ar.c1a", 1, 1, 0);
    step(); chk1("ar.rl1", 2, 1, 1);
    step(); chk1("ar.c1b", 1, 1, 0);
    step(); chk1("ar.rl2", 2, 1, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk1("ar.abort", 0, 0, 0);
`else
    // One-shot: value held on load_valid during RUN is ignored, then taken once IDLE
    do_reset();
    enable = 1'b1; load_valid = 1'b1; load_value = 8'd2;
    step();
    load_value = 8'd9;
    chk1("hv.ld", 2, 1, 0);
    step(); chk1("hv.c1", 1, 1, 0);
    step(); chk1("hv.c0", 0, 0, 1);
    step();
    load_valid = 1'b0;
    chk1("hv.reload", 9, 1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
